// File: rtl/fwd_scoreboard.sv
// Execute-stage forwarding/hazard unit: shifting scoreboard of in-flight writes, youngest-match operand select.
// Lookup is combinational (zero latency); stall holds the front end while slot 0 takes a bubble.
module fwd_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int LATW    = 2,
  parameter int SELW    = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic [DEPTH-1:0]        flush_mask,
  input  logic                    iss_valid,
  input  logic [4:0]              iss_rd,
  input  logic [LATW-1:0]         iss_lat,
  input  logic [NUM_SRC-1:0]      src_en,
  input  logic [NUM_SRC*5-1:0]    src_addr,
  input  logic [NUM_SRC*XLEN-1:0] src_rdata,
  input  logic [DEPTH*XLEN-1:0]   slot_data,
  output logic [NUM_SRC*SELW-1:0] src_sel,
  output logic [NUM_SRC*XLEN-1:0] src_fwd_data,
  output logic                    stall,
  output logic [31:0]             stall_cycles
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [LATW-1:0] cnt;
  } slot_t;

  slot_t              slot_q [DEPTH];
  slot_t              slot_d [DEPTH];
  slot_t              kept   [DEPTH];
  logic [31:0]        stall_cycles_q, stall_cycles_d;
  logic [NUM_SRC-1:0] src_stall;

  // Walk oldest to youngest so the youngest matching slot has the final say.
  always_comb begin
    src_sel      = '0;
    src_fwd_data = src_rdata;
    src_stall    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_en[i] && (src_addr[5*i +: 5] != 5'd0)) begin
        for (int k = DEPTH-1; k >= 0; k--) begin
          if (slot_q[k].valid && (slot_q[k].rd == src_addr[5*i +: 5])) begin
            if (slot_q[k].cnt == '0) begin
              src_sel[SELW*i +: SELW]      = SELW'(k+1);
              src_fwd_data[XLEN*i +: XLEN] = slot_data[XLEN*k +: XLEN];
              src_stall[i]                 = 1'b0;
            end else begin
              src_sel[SELW*i +: SELW]      = '0;
              src_fwd_data[XLEN*i +: XLEN] = src_rdata[XLEN*i +: XLEN];
              src_stall[i]                 = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall        = |src_stall;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      kept[k] = slot_q[k];
      if (flush_mask[k]) kept[k].valid = 1'b0;
    end
    slot_d = kept;
    if (advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_d[k] = kept[k-1];
        if (kept[k-1].cnt != '0) slot_d[k].cnt = kept[k-1].cnt - LATW'(1);
      end
      slot_d[0].valid = iss_valid & (iss_rd != 5'd0) & ~stall & ~(|flush_mask);
      slot_d[0].rd    = iss_rd;
      slot_d[0].cnt   = iss_lat;
    end
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) slot_q[k] <= slot_d[k];
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: per-scenario step tables, expectations queued on drive and popped at negedge.
module tb_fwd_scoreboard;

  logic        clk;
  logic        rst;
  logic        advance;
  logic [1:0]  flush_mask;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [1:0]  iss_lat;
  logic [1:0]  src_en;
  logic [9:0]  src_addr;
  logic [63:0] src_rdata;
  logic [63:0] slot_data;
  logic [3:0]  src_sel;
  logic [63:0] src_fwd_data;
  logic        stall;
  logic [31:0] stall_cycles;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst), .advance(advance), .flush_mask(flush_mask),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_lat(iss_lat),
    .src_en(src_en), .src_addr(src_addr), .src_rdata(src_rdata), .slot_data(slot_data),
    .src_sel(src_sel), .src_fwd_data(src_fwd_data), .stall(stall), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       adv;
    bit [1:0] fm;
    bit       iv;
    bit [4:0] rd;
    bit [1:0] lat;
    bit [1:0] en;
    bit [4:0] a0, a1;
    bit [1:0] s0, s1;
    bit       stl;
  } step_t;

  typedef struct {
    logic [3:0]  sel;
    logic [63:0] dat;
    logic        stl;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 0;

  function automatic step_t mk(bit adv, bit [1:0] fm, bit iv, bit [4:0] rd, bit [1:0] lat,
                               bit [1:0] en, bit [4:0] a0, bit [4:0] a1,
                               bit [1:0] s0, bit [1:0] s1, bit stl);
    step_t s;
    s.adv = adv; s.fm = fm; s.iv = iv; s.rd = rd; s.lat = lat; s.en = en;
    s.a0 = a0; s.a1 = a1; s.s0 = s0; s.s1 = s1; s.stl = stl;
    return s;
  endfunction

  // Drives one cycle of stimulus and queues what the outputs must show for it.
  task automatic apply(input step_t s);
    exp_t        e;
    logic [31:0] d [2];
    logic [1:0]  sl;
    advance = s.adv; flush_mask = s.fm; iss_valid = s.iv; iss_rd = s.rd; iss_lat = s.lat;
    src_en = s.en; src_addr = {s.a1, s.a0};
    for (int i = 0; i < 2; i++) begin
      sl = (i == 0) ? s.s0 : s.s1;
      if (sl == 2'd0) d[i] = src_rdata[32*i +: 32];
      else if (sl == 2'd1) d[i] = slot_data[31:0];
      else d[i] = slot_data[63:32];
    end
    e.sel = {s.s1, s.s0};
    e.dat = {d[1], d[0]};
    e.stl = s.stl;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0; advance = 1'b0; iss_valid = 1'b0; src_en = 2'b00; flush_mask = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    src_rdata = {32'h1111_1111, 32'h2222_2222};
    slot_data = {32'hA5A5_0001, 32'hA5A5_0000};
    rst = 1'b0; advance = 1'b1; iss_valid = 1'b1; iss_rd = 5'd5; iss_lat = 2'd0;
    flush_mask = 2'b00; src_en = 2'b11; src_addr = {5'd5, 5'd5};
    @(posedge clk); #1;
    exp_cnt = 0;
    st.push_back(mk(1, 0, 1, 5, 0, 2'b11, 5, 5, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 5, 0, 2'b11, 5, 5, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b00, 5, 5, 0, 0, 0));
    foreach (st[j]) begin
      apply(st[j]);
      rst = (j == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (src_sel !== e.sel) begin n_err++; $display("FAIL reset[%0d] sel got %h want %h", j, src_sel, e.sel); end
      n_cmp++; if (src_fwd_data !== e.dat) begin n_err++; $display("FAIL reset[%0d] data got %h want %h", j, src_fwd_data, e.dat); end
      n_cmp++; if (stall !== e.stl) begin n_err++; $display("FAIL reset[%0d] stall got %b want %b", j, stall, e.stl); end
      n_cmp++; if (stall_cycles !== exp_cnt) begin n_err++; $display("FAIL reset[%0d] stall_cycles got %h want %h", j, stall_cycles, exp_cnt); end
      if (e.stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ex_fwd();
    step_t st[$];
    exp_t  e;
    do_reset();
    slot_data = {32'h0BAD_0BAD, 32'hDEAD_BEEF};
    st.push_back(mk(1, 0, 1, 5, 0, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b01, 5, 0, 1, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 5, 5, 1, 1, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 6, 4, 0, 0, 0));
    foreach (st[j]) begin
      apply(st[j]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (src_sel !== e.sel) begin n_err++; $display("FAIL ex_fwd[%0d] sel got %h want %h", j, src_sel, e.sel); end
      n_cmp++; if (src_fwd_data !== e.dat) begin n_err++; $display("FAIL ex_fwd[%0d] data got %h want %h", j, src_fwd_data, e.dat); end
      n_cmp++; if (stall !== e.stl) begin n_err++; $display("FAIL ex_fwd[%0d] stall got %b want %b", j, stall, e.stl); end
      if (e.stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    step_t st[$];
    exp_t  e;
    do_reset();
    slot_data = {32'hAAAA_0007, 32'hBBBB_0007};
    st.push_back(mk(1, 0, 1, 7, 0, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 7, 0, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 7, 7, 1, 1, 0));
    st.push_back(mk(1, 0, 1, 7, 1, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b01, 7, 0, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 7, 0, 0, 1));
    foreach (st[j]) begin
      apply(st[j]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (src_sel !== e.sel) begin n_err++; $display("FAIL youngest[%0d] sel got %h want %h", j, src_sel, e.sel); end
      n_cmp++; if (src_fwd_data !== e.dat) begin n_err++; $display("FAIL youngest[%0d] data got %h want %h", j, src_fwd_data, e.dat); end
      n_cmp++; if (stall !== e.stl) begin n_err++; $display("FAIL youngest[%0d] stall got %b want %b", j, stall, e.stl); end
      n_cmp++; if (stall_cycles !== exp_cnt) begin n_err++; $display("FAIL youngest[%0d] stall_cycles got %h want %h", j, stall_cycles, exp_cnt); end
      if (e.stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    exp_t  e;
    do_reset();
    slot_data = {32'h3333_0003, 32'h4444_0004};
    st.push_back(mk(1, 0, 1, 3, 1, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 4, 0, 2'b01, 3, 0, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 3, 4, 2, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    foreach (st[j]) begin
      apply(st[j]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (src_sel !== e.sel) begin n_err++; $display("FAIL load_use[%0d] sel got %h want %h", j, src_sel, e.sel); end
      n_cmp++; if (src_fwd_data !== e.dat) begin n_err++; $display("FAIL load_use[%0d] data got %h want %h", j, src_fwd_data, e.dat); end
      n_cmp++; if (stall !== e.stl) begin n_err++; $display("FAIL load_use[%0d] stall got %b want %b", j, stall, e.stl); end
      n_cmp++; if (stall_cycles !== exp_cnt) begin n_err++; $display("FAIL load_use[%0d] stall_cycles got %h want %h", j, stall_cycles, exp_cnt); end
      if (e.stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_disabled();
    step_t st[$];
    exp_t  e;
    do_reset();
    slot_data = {32'h6666_0001, 32'h6666_0000};
    st.push_back(mk(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 6, 2, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b00, 6, 6, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 6, 0, 0, 1));
    st.push_back(mk(1, 0, 0, 0, 0, 2'b00, 6, 6, 0, 0, 0));
    // x6 now sits in the oldest slot with one cycle still to go.
    st.push_back(mk(0, 0, 0, 0, 0, 2'b01, 6, 0, 0, 0, 1));
    st.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 6, 6, 0, 0, 0));
    foreach (st[j]) begin
      apply(st[j]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (src_sel !== e.sel) begin n_err++; $display("FAIL x0_dis[%0d] sel got %h want %h", j, src_sel, e.sel); end
      n_cmp++; if (src_fwd_data !== e.dat) begin n_err++; $display("FAIL x0_dis[%0d] data got %h want %h", j, src_fwd_data, e.dat); end
      n_cmp++; if (stall !== e.stl) begin n_err++; $display("FAIL x0_dis[%0d] stall got %b want %b", j, stall, e.stl); end
      n_cmp++; if (stall_cycles !== exp_cnt) begin n_err++; $display("FAIL x0_dis[%0d] stall_cycles got %h want %h", j, stall_cycles, exp_cnt); end
      if (e.stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    step_t st[$];
    exp_t  e;
    do_reset();
    slot_data = {32'h9999_0001, 32'h9999_0000};
    st.push_back(mk(1, 0, 1, 9, 0, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 2'b01, 1, 9, 0, 2'b01, 9, 0, 1, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 10, 0, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 2'b01, 0, 0, 0, 2'b01, 10, 0, 1, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b01, 10, 0, 0, 0, 0));
    st.push_back(mk(1, 0, 1, 11, 1, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 2'b01, 0, 0, 0, 2'b01, 11, 0, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b11, 11, 11, 0, 0, 0));
    foreach (st[j]) begin
      apply(st[j]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (src_sel !== e.sel) begin n_err++; $display("FAIL flush[%0d] sel got %h want %h", j, src_sel, e.sel); end
      n_cmp++; if (src_fwd_data !== e.dat) begin n_err++; $display("FAIL flush[%0d] data got %h want %h", j, src_fwd_data, e.dat); end
      n_cmp++; if (stall !== e.stl) begin n_err++; $display("FAIL flush[%0d] stall got %b want %b", j, stall, e.stl); end
      n_cmp++; if (stall_cycles !== exp_cnt) begin n_err++; $display("FAIL flush[%0d] stall_cycles got %h want %h", j, stall_cycles, exp_cnt); end
      if (e.stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    step_t st[$];
    exp_t  e;
    do_reset();
    st.push_back(mk(1, 0, 1, 12, 2, 2'b00, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b01, 12, 0, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b01, 12, 0, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b01, 12, 0, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 2'b00, 12, 0, 0, 0, 0));
    foreach (st[j]) begin
      apply(st[j]);
      if (j == 1) begin
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles_q;
        exp_cnt = 32'hFFFF_FFFE;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if (stall !== e.stl) begin n_err++; $display("FAIL sat[%0d] stall got %b want %b", j, stall, e.stl); end
      n_cmp++; if (stall_cycles !== exp_cnt) begin n_err++; $display("FAIL sat[%0d] stall_cycles got %h want %h", j, stall_cycles, exp_cnt); end
      if (e.stl && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; advance = 1'b0; flush_mask = 2'b00; iss_valid = 1'b0; iss_rd = 5'd0;
    iss_lat = 2'd0; src_en = 2'b00; src_addr = '0;
    src_rdata = {32'h1111_1111, 32'h2222_2222};
    slot_data = '0;
    test_reset();
    test_ex_fwd();
    test_youngest();
    test_load_use();
    test_x0_disabled();
    test_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the riscv_core execute stage.
- Tracks DEPTH in-flight register writes in a shifting scoreboard.
- For NUM_SRC source operands, it selects between regfile data and any in-flight slot result, youngest match first.
- Raises a load-use stall when the matching producer's result is not yet available. Also keeps a saturating stall-cycle performance counter.

Parameters:
- XLEN, 32, datapath width
- NUM_SRC, 2, number of source operands looked up per cycle
- DEPTH, 2, in-flight slots; slot 0 is youngest (EX result), slot DEPTH-1 is oldest (writing the regfile this cycle)
- LATW, 2, width of the per-entry result-latency countdown
- SELW, $clog2(DEPTH+1), width of each operand select field (derived; do not override)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- advance  in  1  pipeline advances this cycle (slots shift)
- flush_mask  in  DEPTH  bit k set invalidates slot k at this edge; any set bit also drops the issuing entry
- iss_valid  in  1  instruction entering slot 0 writes a register
- iss_rd  in  5  destination register of the issuing instruction
- iss_lat  in  LATW  advances until its result is valid (0 = available in slot 0; load = 1)
- src_en  in  NUM_SRC  operand i actually reads a register
- src_addr  in  NUM_SRC*5  source register addresses, operand i at [5i+:5]
- src_rdata  in  NUM_SRC*XLEN  regfile read data
- slot_data  in  DEPTH*XLEN  result data held by each pipeline slot
- src_sel  out  NUM_SRC*SELW  per operand: 0 = regfile, k+1 = slot k
- src_fwd_data  out  NUM_SRC*XLEN  selected operand data
- stall  out  1  hold front end and insert a bubble
- stall_cycles  out  32  saturating count of cycles with stall=1

Behaviour:
- Slot state, per slot: valid, rd[4:0], cnt[LATW-1:0].
- Reset (rst=0 at an edge): all valid=0, cnt=0, stall_cycles=0. Consequently stall=0, src_sel=0 and src_fwd_data=src_rdata. Reset overrides advance and flush in the same cycle.
- Lookup is combinational, with zero latency from src_addr/slot state to outputs. For each operand i:
  - If src_en[i]=0 or src_addr=0: sel=0, data=src_rdata, no stall contribution. x0 is never forwarded.
  - Otherwise, take the lowest-index valid slot k with rd==src_addr.
  - If cnt==0: sel=k+1, data=slot_data[k].
  - If cnt!=0: sel=0 and the operand requests a stall.
  - Older matching slots are ignored when a younger match exists, including when the younger one is stalling.
  - No match: sel=0, data=src_rdata.
- stall is the OR of operand stall requests. It is independent of flush_mask in the same cycle.
- Update at a clock edge, when rst=1 and advance=1:
  - Apply flush_mask to the current contents first.
  - Then shift: slot[k+1] <= slot[k], with cnt decremented and saturating at 0.
  - Slot DEPTH-1 is discarded.
  - slot[0] <= {valid = iss_valid & (iss_rd!=0) & ~stall & ~|flush_mask, rd = iss_rd, cnt = iss_lat}.
  - When stall=1, slot 0 becomes a bubble (valid=0) while older slots still shift. This is what resolves the load-use hazard.
- When advance=0: no shift and no decrement; flush_mask still invalidates slots.
- stall_cycles increments on every clock with rst=1 and stall=1, advance irrelevant. It holds at 32'hFFFF_FFFF.
- Slots with cnt>0 reaching slot DEPTH-1 are legal. Their result is not forwardable until cnt reaches 0, so a matching consumer stalls.
- Width rules: src_sel fields are zero-extended indices. Packed buses are little-endian by operand or slot index.

Test Plan:
- Reset: hold rst=0 two cycles with iss_valid=1, advance=1 -> after release: stall=0, src_sel=0, stall_cycles=0, src_fwd_data==src_rdata.
- EX→EX forward:
  - Stimulus: issue rd=5 with lat=0, advance once; then src_addr[0]=5, src_en=1, slot_data[0]=32'hDEADBEEF.
  - Required: src_sel[0]=1, src_fwd_data[0]=32'hDEADBEEF, stall=0.
- Youngest-wins:
  - Stimulus: issue rd=7 (data A), then rd=7 (data B), both lat=0.
  - Required: operand reading x7 gets sel=1 with data B, not sel=2.
- Load-use:
  - Stimulus: issue rd=3 with lat=1, advance; consumer reads x3.
  - Required: stall=1 for one cycle and stall_cycles=1. On the next advance, slot 0 is a bubble. Then sel=2, stall=0.
- x0 and disabled operands:
  - Stimulus: issue rd=0 lat=0; read x0. Separately, src_en=0 on a matching address with cnt>0.
  - Required: sel=0 and stall=0 in both cases.
- Flush and saturation:
  - Stimulus: flush_mask=2'b01 with advance=1 and an issuing rd=9.
  - Required: slot 0 and slot 1 are both invalid after the edge, and a read of x9 gives sel=0.
  - Force stall_cycles to 32'hFFFF_FFFE and stall for 3 cycles -> it ends at 32'hFFFF_FFFF.
